// File: rtl/mm_pkg.sv
// Shared definitions for the N x N matrix multiplier: FSM encoding,
// accumulator width derivation and packed-element index helper.
package mm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mm_state_t;

    // Wide enough for the largest exact dot product of N DW-bit products.
    function automatic int acc_width(input int n, input int dw);
        return 2 * dw + $clog2(n);
    endfunction

    // Bit offset of element (r,c) in a row-major flat-packed matrix.
    function automatic int elem_idx(input int r, input int c, input int n, input int dw);
        return (r * n + c) * dw;
    endfunction

endpackage

// File: rtl/mm_mac_unit.sv
// Single multiply-accumulate lane: DW x DW product, exact accumulator and a
// combinational saturate/wrap converter on acc+product.
module mm_mac_unit
    import mm_pkg::*;
#(
    parameter int DW    = 8,
    parameter int ACC_W = 17
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_clr,
    input  logic          i_en,
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    input  logic          i_sat_en,
    output logic [DW-1:0] o_elem,
    output logic          o_ovf
);

    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_prod;
    logic [ACC_W-1:0] w_sum;
    logic [DW:0]      w_conv;

    // {overflow, element}: out-of-range values clamp or keep their low DW bits.
    function automatic logic [DW:0] convert(input logic [ACC_W-1:0] v, input logic sat);
        logic          big;
        logic [DW-1:0] e;
        big = |v[ACC_W-1:DW];
        e   = (big && sat) ? {DW{1'b1}} : v[DW-1:0];
        return {big, e};
    endfunction

    assign w_prod = ACC_W'(i_a) * ACC_W'(i_b);
    assign w_sum  = r_acc + w_prod;
    assign w_conv = convert(w_sum, i_sat_en);
    assign o_elem = w_conv[DW-1:0];
    assign o_ovf  = w_conv[DW];

    // Accumulator: cleared at job start and after each finished dot product.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= w_sum;
        end
    end

endmodule

// File: rtl/matrix_mult_nxn.sv
// N x N unsigned matrix multiplier C = A x B, one MAC per cycle, driven by a
// start/busy/done handshake with selectable saturate or wrap result mode.
module matrix_mult_nxn
    import mm_pkg::*;
#(
    parameter int N     = 2,
    parameter int DW    = 8,
    parameter int ACC_W = acc_width(N, DW)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              sat_en,
    input  logic [N*N*DW-1:0] A,
    input  logic [N*N*DW-1:0] B,
    output logic [N*N*DW-1:0] C,
    output logic              busy,
    output logic              done,
    output logic              ovf
);

    localparam int            IW   = $clog2(N);
    localparam int            MW   = N * N * DW;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    mm_state_t     r_state;
    logic [MW-1:0] r_a;
    logic [MW-1:0] r_b;
    logic [MW-1:0] r_res;
    logic          r_sat;
    logic          r_ovf_job;
    logic [IW-1:0] r_i;
    logic [IW-1:0] r_j;
    logic [IW-1:0] r_k;

    logic          w_run;
    logic          w_accept;
    logic          w_last_k;
    logic          w_final;
    logic          w_clr;
    logic [DW-1:0] w_a_el;
    logic [DW-1:0] w_b_el;
    logic [DW-1:0] w_elem;
    logic          w_elem_ovf;
    logic [MW-1:0] w_res_next;
    logic          w_ovf_next;

    assign w_run    = (r_state == ST_RUN);
    assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_last_k = w_run && (r_k == LAST);
    assign w_final  = w_last_k && (r_i == LAST) && (r_j == LAST);
    assign w_clr    = w_accept || w_last_k;
    assign w_a_el   = r_a[elem_idx(int'(r_i), int'(r_k), N, DW) +: DW];
    assign w_b_el   = r_b[elem_idx(int'(r_k), int'(r_j), N, DW) +: DW];

    mm_mac_unit #(
        .DW    (DW),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk      (clk),
        .reset    (reset),
        .i_clr    (w_clr),
        .i_en     (w_run),
        .i_a      (w_a_el),
        .i_b      (w_b_el),
        .i_sat_en (r_sat),
        .o_elem   (w_elem),
        .o_ovf    (w_elem_ovf)
    );

    // Merge the element finishing this cycle into the internal result image.
    always_comb begin
        w_res_next = r_res;
        w_ovf_next = r_ovf_job;
        if (w_last_k) begin
            w_res_next[elem_idx(int'(r_i), int'(r_j), N, DW) +: DW] = w_elem;
            w_ovf_next = r_ovf_job | w_elem_ovf;
        end
    end

    // Control FSM, i/j/k loop counters, operand latches and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_res     <= '0;
            r_sat     <= 1'b0;
            r_ovf_job <= 1'b0;
            r_i       <= '0;
            r_j       <= '0;
            r_k       <= '0;
            C         <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                    if (start) begin
                        r_a       <= A;
                        r_b       <= B;
                        r_sat     <= sat_en;
                        r_res     <= '0;
                        r_ovf_job <= 1'b0;
                        r_i       <= '0;
                        r_j       <= '0;
                        r_k       <= '0;
                        busy      <= 1'b1;
                        r_state   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_res     <= w_res_next;
                    r_ovf_job <= w_ovf_next;
                    // k innermost, then j, then i; all wrap to 0 after the last MAC.
                    if (r_k == LAST) begin
                        r_k <= '0;
                        if (r_j == LAST) begin
                            r_j <= '0;
                            r_i <= (r_i == LAST) ? '0 : r_i + IW'(1);
                        end else begin
                            r_j <= r_j + IW'(1);
                        end
                    end else begin
                        r_k <= r_k + IW'(1);
                    end
                    if (w_final) begin
                        C       <= w_res_next;
                        ovf     <= w_ovf_next;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= ST_DONE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_mult_nxn.sv
// Self-checking bench for matrix_mult_nxn: an N=2 and an N=3 instance driven
// by directed and random jobs, compared against a plain-arithmetic model.
module tb_matrix_mult_nxn;

    logic        clk;
    logic        reset;
    logic        start2, sat2, busy2, done2, ovf2;
    logic [31:0] A2, B2, C2;
    logic        start3, sat3, busy3, done3, ovf3;
    logic [71:0] A3, B3, C3;

    int          n_checks;
    int          n_fail;
    logic [31:0] exp_prev2;
    logic [71:0] exp_prev3;

    matrix_mult_nxn #(.N(2), .DW(8)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .sat_en(sat2),
        .A(A2), .B(B2), .C(C2), .busy(busy2), .done(done2), .ovf(ovf2)
    );

    matrix_mult_nxn #(.N(3), .DW(8)) dut3 (
        .clk(clk), .reset(reset), .start(start3), .sat_en(sat3),
        .A(A3), .B(B3), .C(C3), .busy(busy3), .done(done3), .ovf(ovf3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: exact dot products, then clamp or keep the low byte.
    function automatic void model(input logic [71:0] a, input logic [71:0] b, input int n,
                                  input logic s, output logic [71:0] c, output logic o);
        int sum;
        c = '0;
        o = 1'b0;
        for (int r = 0; r < n; r++) begin
            for (int col = 0; col < n; col++) begin
                sum = 0;
                for (int k = 0; k < n; k++)
                    sum += int'(a[(r*n+k)*8 +: 8]) * int'(b[(k*n+col)*8 +: 8]);
                if (sum > 255) begin
                    o = 1'b1;
                    c[(r*n+col)*8 +: 8] = s ? 8'hFF : 8'(sum);
                end else begin
                    c[(r*n+col)*8 +: 8] = 8'(sum);
                end
            end
        end
    endfunction

    task automatic run2(input logic [31:0] a, input logic [31:0] b, input logic s, input string nm);
        logic [71:0] ec;
        logic        eo;
        int          n;
        int          bc;
        model(72'(a), 72'(b), 2, s, ec, eo);
        @(negedge clk);
        A2 = a; B2 = b; sat2 = s; start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        n = 1; bc = 0;
        while (done2 !== 1'b1 && n <= 40) begin
            if (busy2 === 1'b1) bc++;
            n_checks++;
            if (C2 !== exp_prev2) begin
                $display("FAIL %s hold n=%0d: C=%h expected %h", nm, n, C2, exp_prev2); n_fail++;
            end
            @(posedge clk); #1;
            n++;
        end
        n_checks++;
        if (n !== 9) begin $display("FAIL %s latency: got %0d expected 9", nm, n); n_fail++; end
        n_checks++;
        if (bc !== 8) begin $display("FAIL %s busy cycles: got %0d expected 8", nm, bc); n_fail++; end
        n_checks++;
        if (C2 !== ec[31:0]) begin $display("FAIL %s C: got %h expected %h", nm, C2, ec[31:0]); n_fail++; end
        n_checks++;
        if (ovf2 !== eo) begin $display("FAIL %s ovf: got %b expected %b", nm, ovf2, eo); n_fail++; end
        exp_prev2 = ec[31:0];
        @(posedge clk); #1;
        n_checks++;
        if (done2 !== 1'b0) begin $display("FAIL %s done width: got %b expected 0", nm, done2); n_fail++; end
    endtask

    task automatic run3(input logic [71:0] a, input logic [71:0] b, input logic s, input string nm);
        logic [71:0] ec;
        logic        eo;
        int          n;
        int          bc;
        model(a, b, 3, s, ec, eo);
        @(negedge clk);
        A3 = a; B3 = b; sat3 = s; start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        n = 1; bc = 0;
        while (done3 !== 1'b1 && n <= 60) begin
            if (busy3 === 1'b1) bc++;
            @(posedge clk); #1;
            n++;
        end
        n_checks++;
        if (n !== 28) begin $display("FAIL %s latency: got %0d expected 28", nm, n); n_fail++; end
        n_checks++;
        if (bc !== 27) begin $display("FAIL %s busy cycles: got %0d expected 27", nm, bc); n_fail++; end
        n_checks++;
        if (C3 !== ec) begin $display("FAIL %s C: got %h expected %h", nm, C3, ec); n_fail++; end
        n_checks++;
        if (ovf3 !== eo) begin $display("FAIL %s ovf: got %b expected %b", nm, ovf3, eo); n_fail++; end
        exp_prev3 = ec;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (C2 !== 32'h0) begin $display("FAIL reset C2: got %h expected 0", C2); n_fail++; end
        n_checks++;
        if ({busy2, done2, ovf2} !== 3'b000) begin
            $display("FAIL reset ctl2: got busy/done/ovf=%b expected 000", {busy2, done2, ovf2}); n_fail++;
        end
        n_checks++;
        if (C3 !== 72'h0) begin $display("FAIL reset C3: got %h expected 0", C3); n_fail++; end
        n_checks++;
        if ({busy3, done3, ovf3} !== 3'b000) begin
            $display("FAIL reset ctl3: got busy/done/ovf=%b expected 000", {busy3, done3, ovf3}); n_fail++;
        end
        reset = 1'b0;
        exp_prev2 = '0;
        exp_prev3 = '0;
    endtask

    task automatic test_basic();
        run2(32'h04030201, 32'h08070605, 1'b0, "basic");
        n_checks++;
        if (C2 !== 32'h322B1613) begin $display("FAIL basic literal C: got %h expected 322b1613", C2); n_fail++; end
        n_checks++;
        if (ovf2 !== 1'b0) begin $display("FAIL basic literal ovf: got %b expected 0", ovf2); n_fail++; end
    endtask

    task automatic test_ff_wrap();
        run2(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, "ff_wrap");
        n_checks++;
        if (C2 !== 32'h02020202) begin $display("FAIL ff_wrap literal C: got %h expected 02020202", C2); n_fail++; end
        n_checks++;
        if (ovf2 !== 1'b1) begin $display("FAIL ff_wrap literal ovf: got %b expected 1", ovf2); n_fail++; end
    endtask

    task automatic test_ff_sat();
        run2(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, "ff_sat");
        n_checks++;
        if (C2 !== 32'hFFFFFFFF) begin $display("FAIL ff_sat literal C: got %h expected ffffffff", C2); n_fail++; end
        n_checks++;
        if (ovf2 !== 1'b1) begin $display("FAIL ff_sat literal ovf: got %b expected 1", ovf2); n_fail++; end
    endtask

    task automatic test_n3_identity();
        logic [71:0] id;
        logic [71:0] bm;
        id = 72'h01_00_00_00_01_00_00_00_01;
        bm = 72'h09_08_07_06_05_04_03_02_01;
        run3(id, bm, 1'b0, "n3_identity");
        n_checks++;
        if (C3 !== bm) begin $display("FAIL n3_identity literal C: got %h expected %h", C3, bm); n_fail++; end
    endtask

    task automatic test_ignore_start();
        logic [71:0] e1;
        logic        o1;
        logic [31:0] a1, b1;
        int          cnt, first;
        a1 = $urandom(); b1 = $urandom();
        model(72'(a1), 72'(b1), 2, 1'b1, e1, o1);
        @(negedge clk);
        A2 = a1; B2 = b1; sat2 = 1'b1; start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        cnt = 0; first = 0;
        for (int n = 1; n <= 20; n++) begin
            if (done2 === 1'b1) begin
                cnt++;
                if (first == 0) begin
                    first = n;
                    n_checks++;
                    if (C2 !== e1[31:0]) begin $display("FAIL ignore C: got %h expected %h", C2, e1[31:0]); n_fail++; end
                    n_checks++;
                    if (ovf2 !== o1) begin $display("FAIL ignore ovf: got %b expected %b", ovf2, o1); n_fail++; end
                end
            end
            if (n == 3) begin
                start2 = 1'b1; A2 = ~a1; B2 = b1 ^ 32'h5A5A5A5A; sat2 = 1'b0;
            end
            if (n == 4) start2 = 1'b0;
            @(posedge clk); #1;
        end
        n_checks++;
        if (cnt !== 1) begin $display("FAIL ignore done count: got %0d expected 1", cnt); n_fail++; end
        n_checks++;
        if (first !== 9) begin $display("FAIL ignore latency: got %0d expected 9", first); n_fail++; end
        exp_prev2 = e1[31:0];
    endtask

    task automatic test_reset_mid_job();
        @(negedge clk);
        A2 = $urandom(); B2 = $urandom(); sat2 = 1'b0; start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (C2 !== 32'h0) begin $display("FAIL midreset C: got %h expected 0", C2); n_fail++; end
        n_checks++;
        if ({busy2, done2, ovf2} !== 3'b000) begin
            $display("FAIL midreset ctl: got busy/done/ovf=%b expected 000", {busy2, done2, ovf2}); n_fail++;
        end
        reset = 1'b0;
        exp_prev2 = '0;
        exp_prev3 = '0;
        run2(32'h04030201, 32'h08070605, 1'b0, "after_reset");
    endtask

    task automatic test_back_to_back();
        logic [71:0] e1, e2;
        logic        o1, o2;
        logic [31:0] a1, b1, a2, b2;
        int          n, d1, d2;
        a1 = $urandom(); b1 = $urandom(); a2 = $urandom() & 32'h0F0F0F0F; b2 = $urandom() & 32'h0F0F0F0F;
        model(72'(a1), 72'(b1), 2, 1'b0, e1, o1);
        model(72'(a2), 72'(b2), 2, 1'b0, e2, o2);
        @(negedge clk);
        A2 = a1; B2 = b1; sat2 = 1'b0; start2 = 1'b1;
        @(posedge clk); #1;
        n = 1; d1 = 0; d2 = 0;
        while (d2 == 0 && n <= 60) begin
            if (done2 === 1'b1) begin
                if (d1 == 0) begin
                    d1 = n;
                    n_checks++;
                    if (C2 !== e1[31:0]) begin $display("FAIL b2b C1: got %h expected %h", C2, e1[31:0]); n_fail++; end
                    A2 = a2; B2 = b2;
                end else begin
                    d2 = n;
                    n_checks++;
                    if (C2 !== e2[31:0]) begin $display("FAIL b2b C2: got %h expected %h", C2, e2[31:0]); n_fail++; end
                    n_checks++;
                    if (ovf2 !== o2) begin $display("FAIL b2b ovf2: got %b expected %b", ovf2, o2); n_fail++; end
                end
            end else begin
                if (d1 != 0 && n == d1 + 1) start2 = 1'b0;
                n_checks++;
                if (C2 !== ((d1 == 0) ? exp_prev2 : e1[31:0])) begin
                    $display("FAIL b2b hold n=%0d: got %h expected %h", n, C2, (d1 == 0) ? exp_prev2 : e1[31:0]);
                    n_fail++;
                end
            end
            @(posedge clk); #1;
            n++;
        end
        start2 = 1'b0;
        n_checks++;
        if (d1 !== 9) begin $display("FAIL b2b first latency: got %0d expected 9", d1); n_fail++; end
        n_checks++;
        if (d2 - d1 !== 9) begin $display("FAIL b2b spacing: got %0d expected 9", d2 - d1); n_fail++; end
        exp_prev2 = e2[31:0];
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        for (int t = 0; t < 8; t++) begin
            a = $urandom(); b = $urandom();
            if (t % 2 == 0) begin a = a & 32'h3F3F3F3F; b = b & 32'h3F3F3F3F; end
            run2(a, b, 1'($urandom_range(0, 1)), "random2");
        end
        for (int t = 0; t < 3; t++)
            run3({8'($urandom()), $urandom(), $urandom()}, {8'($urandom()), $urandom(), $urandom()},
                 1'($urandom_range(0, 1)), "random3");
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        reset = 1'b1;
        start2 = 1'b0; sat2 = 1'b0; A2 = '0; B2 = '0;
        start3 = 1'b0; sat3 = 1'b0; A3 = '0; B3 = '0;
        exp_prev2 = '0; exp_prev3 = '0;
        test_reset();
        test_basic();
        test_ff_wrap();
        test_ff_sat();
        test_n3_identity();
        test_ignore_start();
        test_reset_mid_job();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
